// File: rtl/mod_req_issuer.sv
// Request sequencer: issues a programmed number of four-phase req_valid/req_ready handshakes.
// Optional watchdog timeout enabled by defining MOD_REQ_ISSUER_TIMEOUT_EN.
module mod_req_issuer #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] issued,
  output logic               req_valid,
  input  logic               req_ready
);

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;

  state_t             state, state_next;
  logic [COUNT_W-1:0] n, n_next;
  logic [COUNT_W-1:0] issued_next, issued_inc;
  logic               busy_next, done_next, req_valid_next;

`ifdef MOD_REQ_ISSUER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog, wdog_next;
  logic            error_next;
`endif

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_next     = state;
    n_next         = n;
    issued_next    = issued;
    busy_next      = busy;
    done_next      = 1'b0;
    req_valid_next = req_valid;
    issued_inc     = issued + COUNT_W'(1);
`ifdef MOD_REQ_ISSUER_TIMEOUT_EN
    error_next     = error;
    wdog_next      = '0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          n_next      = count;
          issued_next = '0;
`ifdef MOD_REQ_ISSUER_TIMEOUT_EN
          error_next  = 1'b0;
`endif
          if (count == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next     = ASSERT;
            req_valid_next = 1'b1;
            busy_next      = 1'b1;
          end
        end
      end
      ASSERT: begin
        if (req_ready) begin
          state_next     = RELEASE;
          req_valid_next = 1'b0;
        end
      end
      RELEASE: begin
        if (!req_ready) begin
          issued_next = issued_inc;
          if (issued_inc == n) begin
            state_next = DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end else begin
            state_next     = ASSERT;
            req_valid_next = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef MOD_REQ_ISSUER_TIMEOUT_EN
    // Watchdog only advances while a handshake phase is stuck in place
    if ((state == ASSERT || state == RELEASE) && state_next == state) begin
      if (wdog == WD_W'(TIMEOUT - 1)) begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
        busy_next      = 1'b0;
        error_next     = 1'b1;
      end else begin
        wdog_next = wdog + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      issued    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      state     <= state_next;
      n         <= n_next;
      issued    <= issued_next;
      busy      <= busy_next;
      done      <= done_next;
      req_valid <= req_valid_next;
    end
  end

`ifdef MOD_REQ_ISSUER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog  <= '0;
      error <= 1'b0;
    end else begin
      wdog  <= wdog_next;
      error <= error_next;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
